// File: rtl/tagged_value_fifo_pkg.sv
// Shared types for the tagged value FIFO: entry tag encoding and a display helper.
// Optional pop-side tag checking is enabled by defining TVF_TYPE_CHECK_EN.
package tagged_value_pkg;

  localparam int unsigned TAG_W = 2;

  typedef enum logic [TAG_W-1:0] {
    TAG_NONE = 2'd0,
    TAG_INT  = 2'd1,
    TAG_STR  = 2'd2,
    TAG_REAL = 2'd3
  } tag_e;

  function automatic string tag_name(input tag_e t);
    case (t)
      TAG_INT:  return "INT";
      TAG_STR:  return "STR";
      TAG_REAL: return "REAL";
      default:  return "NONE";
    endcase
  endfunction

endpackage

// File: rtl/tagged_value_fifo_if.sv
// Producer/consumer handshake bundle of the tagged value FIFO.
// The FIFO takes the slave modport; the driving agent takes master.
interface tagged_value_fifo_if
  import tagged_value_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  push_valid;
  logic                  push_ready;
  tag_e                  push_tag;
  logic [DATA_WIDTH-1:0] push_data;

  logic                  pop_valid;
  logic                  pop_ready;
  tag_e                  pop_expect_tag;
  tag_e                  pop_tag;
  logic [DATA_WIDTH-1:0] pop_data;

  modport slave (
    input  push_valid, push_tag, push_data, pop_ready, pop_expect_tag,
    output push_ready, pop_valid, pop_tag, pop_data
  );

  modport master (
    output push_valid, push_tag, push_data, pop_ready, pop_expect_tag,
    input  push_ready, pop_valid, pop_tag, pop_data
  );

endinterface

// File: rtl/tagged_value_fifo_mem.sv
// Entry storage: one synchronous write port, one combinational read port.
// The array carries no reset; validity is tracked by the pointers in the top.
module tagged_value_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tagged_value_fifo.sv
// DEPTH-entry FIFO of tagged payloads with per-tag occupancy counts and sticky error flags.
// Define TVF_TYPE_CHECK_EN to make pops require pop_tag == pop_expect_tag.
module tagged_value_fifo
  import tagged_value_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  tagged_value_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     int_count,
  output logic [$clog2(DEPTH):0]     str_count,
  output logic [$clog2(DEPTH):0]     real_count,
  output logic                       illegal_tag_err,
  output logic                       type_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = TAG_W + DATA_WIDTH;

  typedef struct packed {
    tag_e                  tag;
    logic [DATA_WIDTH-1:0] data;
  } tv_entry_t;

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_int_count;
  logic [CW-1:0] r_str_count;
  logic [CW-1:0] r_real_count;
  logic          r_illegal_tag_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_tag_ok;
  logic [EW-1:0] w_rdata;
  tv_entry_t     w_head;
  tv_entry_t     w_wentry;
  logic          w_push_int, w_push_str, w_push_real;
  logic          w_pop_int,  w_pop_str,  w_pop_real;

  // Extra wrap bit distinguishes full (wrap bits differ) from empty (all equal).
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_head   = tv_entry_t'(w_rdata);
  assign w_wentry = '{tag: bus.push_tag, data: bus.push_data};

`ifdef TVF_TYPE_CHECK_EN
  logic r_type_err;

  assign w_tag_ok = (w_head.tag == bus.pop_expect_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_err <= 1'b0;
    end else if (clear) begin
      r_type_err <= 1'b0;
    end else if (!w_empty && bus.pop_ready && !w_tag_ok) begin
      r_type_err <= 1'b1;
    end
  end

  assign type_err = r_type_err;
`else
  logic [TAG_W-1:0] w_unused_expect_tag;

  assign w_unused_expect_tag = bus.pop_expect_tag;
  assign w_tag_ok            = 1'b1;
  assign type_err            = 1'b0;
`endif

  assign w_push = bus.push_valid && !w_full && (bus.push_tag != TAG_NONE);
  assign w_pop  = !w_empty && bus.pop_ready && w_tag_ok;

  always_comb begin
    w_push_int  = w_push && (bus.push_tag == TAG_INT);
    w_push_str  = w_push && (bus.push_tag == TAG_STR);
    w_push_real = w_push && (bus.push_tag == TAG_REAL);
    w_pop_int   = w_pop  && (w_head.tag == TAG_INT);
    w_pop_str   = w_pop  && (w_head.tag == TAG_STR);
    w_pop_real  = w_pop  && (w_head.tag == TAG_REAL);
  end

  tagged_value_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push && !clear),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_int_count       <= '0;
      r_str_count       <= '0;
      r_real_count      <= '0;
      r_illegal_tag_err <= 1'b0;
    end else if (clear) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_int_count       <= '0;
      r_str_count       <= '0;
      r_real_count      <= '0;
      r_illegal_tag_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count      <= r_count      + CW'(w_push)      - CW'(w_pop);
      r_int_count  <= r_int_count  + CW'(w_push_int)  - CW'(w_pop_int);
      r_str_count  <= r_str_count  + CW'(w_push_str)  - CW'(w_pop_str);
      r_real_count <= r_real_count + CW'(w_push_real) - CW'(w_pop_real);
      if (bus.push_valid && (bus.push_tag == TAG_NONE)) begin
        r_illegal_tag_err <= 1'b1;
      end
    end
  end

  assign bus.push_ready = !w_full;
  assign bus.pop_valid  = !w_empty;
  assign bus.pop_tag    = w_empty ? TAG_NONE : w_head.tag;
  assign bus.pop_data   = w_empty ? '0 : w_head.data;

  assign count           = r_count;
  assign int_count       = r_int_count;
  assign str_count       = r_str_count;
  assign real_count      = r_real_count;
  assign illegal_tag_err = r_illegal_tag_err;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (r_count == r_int_count + r_str_count + r_real_count)
        else $error("per-tag counts disagree with total occupancy");
    end
  end

endmodule

// File: tb/tb_tagged_value_fifo.sv
// Directed self-checking bench for tagged_value_fifo (DEPTH=8, DATA_WIDTH=32).
// Type-check expectations follow whether TVF_TYPE_CHECK_EN is defined.
module tb_tagged_value_fifo;
  import tagged_value_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [CW-1:0] count, int_count, str_count, real_count;
  logic          illegal_tag_err, type_err;

  int unsigned n_checks;
  int unsigned n_pass;

  tagged_value_fifo_if #(.DATA_WIDTH(DW)) bus ();

  tagged_value_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .bus             (bus),
    .count           (count),
    .int_count       (int_count),
    .str_count       (str_count),
    .real_count      (real_count),
    .illegal_tag_err (illegal_tag_err),
    .type_err        (type_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input tag_e t, input logic [DW-1:0] d);
    bus.push_valid = 1'b1;
    bus.push_tag   = t;
    bus.push_data  = d;
    step();
    bus.push_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.pop_ready = 1'b1;
    step();
    bus.pop_ready = 1'b0;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    bus.push_valid     = 1'b0;
    bus.push_tag       = TAG_NONE;
    bus.push_data      = '0;
    bus.pop_ready      = 1'b0;
    bus.pop_expect_tag = TAG_NONE;
    step();
    step();

    chk("rst_count",      64'(count), 64'd0);
    chk("rst_push_ready", 64'(bus.push_ready), 64'd1);
    chk("rst_pop_valid",  64'(bus.pop_valid), 64'd0);
    chk("rst_pop_tag",    64'(bus.pop_tag), 64'(TAG_NONE));
    chk("rst_pop_data",   64'(bus.pop_data), 64'd0);
    chk("rst_illegal",    64'(illegal_tag_err), 64'd0);
    chk("rst_type_err",   64'(type_err), 64'd0);
    #2 rst_n = 1'b1;
    step();

    // Fill and drain with one of each tag.
    push1(TAG_INT,  32'd42);
    push1(TAG_STR,  32'h4865_6C6C);
    push1(TAG_REAL, 32'h0003_243F);
    chk("fd_count", 64'(count), 64'd3);
    chk("fd_int",   64'(int_count), 64'd1);
    chk("fd_str",   64'(str_count), 64'd1);
    chk("fd_real",  64'(real_count), 64'd1);
    chk("fd_h0_tag",  64'(bus.pop_tag), 64'(TAG_INT));
    chk("fd_h0_data", 64'(bus.pop_data), 64'd42);
    pop1();
    chk("fd_h1_tag",  64'(bus.pop_tag), 64'(TAG_STR));
    chk("fd_h1_data", 64'(bus.pop_data), 64'h4865_6C6C);
    pop1();
    chk("fd_h2_tag",  64'(bus.pop_tag), 64'(TAG_REAL));
    chk("fd_h2_data", 64'(bus.pop_data), 64'h0003_243F);
    pop1();
    chk("fd_empty_tag",   64'(bus.pop_tag), 64'(TAG_NONE));
    chk("fd_empty_valid", 64'(bus.pop_valid), 64'd0);
    chk("fd_empty_count", 64'(count), 64'd0);

    // Full boundary: blocked push held while a pop frees one slot.
    for (int i = 0; i < 8; i++) push1(TAG_INT, DW'(i));
    chk("full_ready", 64'(bus.push_ready), 64'd0);
    chk("full_count", 64'(count), 64'd8);
    bus.push_valid = 1'b1;
    bus.push_tag   = TAG_INT;
    bus.push_data  = 32'hFFFF_FF9C;
    step();
    chk("full_blocked_count", 64'(count), 64'd8);
    bus.pop_ready = 1'b1;
    step();
    bus.pop_ready = 1'b0;
    chk("full_pop_count", 64'(count), 64'd7);
    chk("full_pop_ready", 64'(bus.push_ready), 64'd1);
    step();
    bus.push_valid = 1'b0;
    chk("full_refill_count", 64'(count), 64'd8);
    for (int i = 1; i < 9; i++) begin
      exp_d = (i == 8) ? 32'hFFFF_FF9C : DW'(i);
      chk("full_drain_data", 64'(bus.pop_data), 64'(exp_d));
      pop1();
    end
    chk("full_drain_count", 64'(count), 64'd0);

    // Simultaneous push/pop at count=4, then 20 entries cycled through.
    for (int i = 0; i < 4; i++) begin
      push1(TAG_INT, DW'(100 + i));
      q.push_back(DW'(100 + i));
    end
    bus.push_valid = 1'b1;
    bus.push_tag   = TAG_STR;
    bus.push_data  = 32'h55;
    bus.pop_ready  = 1'b1;
    step();
    void'(q.pop_front());
    q.push_back(32'h55);
    chk("sim_count", 64'(count), 64'd4);
    chk("sim_int",   64'(int_count), 64'd3);
    chk("sim_str",   64'(str_count), 64'd1);
    bus.push_tag = TAG_INT;
    for (int k = 0; k < 20; k++) begin
      chk("wrap_head", 64'(bus.pop_data), 64'(q[0]));
      bus.push_data = DW'(200 + k);
      step();
      void'(q.pop_front());
      q.push_back(DW'(200 + k));
    end
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_int",   64'(int_count), 64'd4);
    chk("wrap_str",   64'(str_count), 64'd0);
    chk("wrap_head_final", 64'(bus.pop_data), 64'd216);

    // Illegal tag, then clear while a legal push is offered.
    push1(TAG_NONE, 32'hDEAD);
    chk("ill_count", 64'(count), 64'd4);
    chk("ill_flag",  64'(illegal_tag_err), 64'd1);
    step();
    chk("ill_sticky", 64'(illegal_tag_err), 64'd1);
    clear = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_tag   = TAG_INT;
    bus.push_data  = 32'd7;
    step();
    clear = 1'b0;
    bus.push_valid = 1'b0;
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_flag",  64'(illegal_tag_err), 64'd0);
    chk("clr_valid", 64'(bus.pop_valid), 64'd0);
    chk("clr_int",   64'(int_count), 64'd0);

    // Pop with the wrong expected tag.
    push1(TAG_INT, 32'h11);
    push1(TAG_STR, 32'h22);
    $display("type check: head %s, expecting %s", tag_name(bus.pop_tag), tag_name(TAG_STR));
    bus.pop_expect_tag = TAG_STR;
    pop1();
`ifdef TVF_TYPE_CHECK_EN
    chk("tc_mis_count", 64'(count), 64'd2);
    chk("tc_mis_err",   64'(type_err), 64'd1);
    chk("tc_mis_head",  64'(bus.pop_data), 64'h11);
    bus.pop_expect_tag = TAG_INT;
    pop1();
    chk("tc_ok_count", 64'(count), 64'd1);
    chk("tc_ok_err",   64'(type_err), 64'd1);
`else
    chk("tc_count", 64'(count), 64'd1);
    chk("tc_err",   64'(type_err), 64'd0);
`endif
    chk("tc_head_tag", 64'(bus.pop_tag), 64'(TAG_STR));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("tc_clr_err", 64'(type_err), 64'd0);

    // Asynchronous reset between edges at count=5.
    for (int i = 0; i < 5; i++) push1(TAG_REAL, DW'(300 + i));
    push1(TAG_NONE, 32'h0);
    chk("mid_count", 64'(count), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count",      64'(count), 64'd0);
    chk("ar_real",       64'(real_count), 64'd0);
    chk("ar_push_ready", 64'(bus.push_ready), 64'd1);
    chk("ar_pop_valid",  64'(bus.pop_valid), 64'd0);
    chk("ar_pop_tag",    64'(bus.pop_tag), 64'(TAG_NONE));
    chk("ar_pop_data",   64'(bus.pop_data), 64'd0);
    chk("ar_illegal",    64'(illegal_tag_err), 64'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", 64'(bus.pop_valid), 64'd0);
    push1(TAG_STR, 32'h99);
    chk("post_push_valid", 64'(bus.pop_valid), 64'd1);
    chk("post_push_data",  64'(bus.pop_data), 64'h99);
    chk("post_push_count", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tagged_value_fifo.md
# tagged_value_fifo

Synthesizable, parametrised successor to the single-slot multi-type container: a DEPTH-entry first-in-first-out queue where every entry carries a type tag (integer, string-chunk or fixed-point real) alongside its DATA_WIDTH payload. It keeps per-type occupancy counts and flags illegal or mismatched accesses. It sits between a producer that emits mixed-type records and a consumer that dispatches on tag.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 2
- DATA_WIDTH, 32, payload bits per entry
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of all entries, counts and error flags
- push_valid  in  1  producer offers an entry
- push_ready  out  1  FIFO can accept; equals !full
- push_tag  in  2  tag_e of offered entry
- push_data  in  DATA_WIDTH  payload of offered entry
- pop_valid  out  1  head entry present; equals !empty
- pop_ready  in  1  consumer takes head entry
- pop_expect_tag  in  2  tag the consumer requires (used only with TVF_TYPE_CHECK_EN)
- pop_tag  out  2  head tag; TAG_NONE when empty
- pop_data  out  DATA_WIDTH  head payload; 0 when empty
- count  out  $clog2(DEPTH)+1  total occupancy
- int_count, str_count, real_count  out  $clog2(DEPTH)+1 each  occupancy per tag
- illegal_tag_err  out  1  sticky; push attempted with TAG_NONE
- type_err  out  1  sticky; pop attempted with wrong tag (macro only; else tied 0)

## Operation
- Push fires on push_valid && push_ready && push_tag != TAG_NONE. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- If push_valid && push_tag == TAG_NONE, no write occurs and illegal_tag_err is set, regardless of whether the FIFO is full.
- Pop fires on pop_valid && pop_ready (&& tag match when checking is enabled). rd_ptr increments modulo DEPTH.
- Show-ahead head: pop_tag and pop_data reflect the entry at rd_ptr combinationally from storage.
- Simultaneous push and pop: both fire, and count is unchanged. The per-type counts add the pushed tag and subtract the popped tag; when the tags are equal, that count is unchanged.
- Full: push_ready = 0 and no push fires. A pop in the same cycle still fires, and push_ready rises the next cycle (no same-cycle pass-through).
- Empty: no pop fires, and no bypass exists. A pushed entry becomes visible the cycle after the push.
- Pointers carry one extra wrap bit. full = ptrs equal except wrap bit; empty = ptrs fully equal.
- Invariant: count == int_count + str_count + real_count at all times.
- clear takes priority over push and pop in the same cycle. It zeroes the pointers, all counts and both error flags. Storage contents are not cleared.

## Timing
- Reset (async assert, sync-to-clk release): pointers = 0, all counts = 0, push_ready = 1, pop_valid = 0, pop_tag = TAG_NONE, pop_data = 0, both error flags = 0.
- Reset asserted mid-transfer discards all contents. No entry survives, and no partial update occurs.
- Latency, push to pop_valid: 1 cycle. Pop to next head presented: same cycle after the clock edge.
- count, per-type counts and error flags are registered and update on the edge that commits the event.
- Handshake: the producer holds push_tag/push_data stable while push_valid && !push_ready. The block never drops an accepted entry.

## Configuration
- TVF_TYPE_CHECK_EN defined:
  - A pop additionally requires pop_tag == pop_expect_tag.
  - On mismatch with pop_valid && pop_ready, nothing is popped, the head remains, and type_err is set (sticky until clear or reset).
- TVF_TYPE_CHECK_EN undefined:
  - pop_expect_tag is ignored, type_err is tied 0, and pops are tag-agnostic.

## Structure
- Package tagged_value_pkg holds:
  - typedef enum logic [1:0] tag_e {TAG_NONE=0, TAG_INT=1, TAG_STR=2, TAG_REAL=3}
  - a packed struct tv_entry_t {tag_e tag; logic [DATA_WIDTH-1:0] data}, parameterised via the module
  - a function for tag-to-string display, used by benches
- Sub-module tagged_value_fifo_mem is the natural split: a DEPTH × (2+DATA_WIDTH) array with one synchronous write port and one combinational read port, plus no reset on the array itself.
- Pointer and count logic plus error flags stay in the top module.

## Test plan
- Fill and drain: push INT 42, STR 0x48656C6C, REAL 0x0003_243F. Expect count=3 and int/str/real counts = 1/1/1. Pop three times; the same order and values come out, then pop_tag=TAG_NONE and pop_valid=0.
- Full boundary (DEPTH=8): push 8 INT entries. Expect push_ready=0 and count=8. Hold push_valid with value −100; nothing is written. One pop makes push_ready=1 next cycle, and −100 is accepted.
- Simultaneous push/pop at count=4: push STR and pop INT in the same cycle. count stays 4, int_count decrements by 1, str_count increments by 1. Verify wrap-around by cycling 20 entries through.
- Illegal tag: push TAG_NONE with data 0xDEAD. No count change, and illegal_tag_err=1 until clear. Then clear with push_valid high: count=0 and the flag drops.
- Type check (with TVF_TYPE_CHECK_EN): head INT, pop with expect TAG_STR. The head remains and type_err=1. Retry with TAG_INT pops. Without the macro, the same stimulus pops and type_err stays 0.
- Reset mid-stream: assert rst_n low asynchronously between edges at count=5. All outputs take reset values immediately. After release, the first push appears at pop_valid one cycle later.
